// File: rtl/mprj_wb_pkg.sv
// Shared definitions for the mprj Wishbone responder.
//   - register offsets inside the 4 KB window (adr[11:0], word aligned)
//   - ID constant, CTRL and STATUS bit positions
//   - bus state machine encoding
package mprj_wb_pkg;

  localparam logic [11:0] OFF_SCRATCH = 12'h000;
  localparam logic [11:0] OFF_CTRL    = 12'h004;
  localparam logic [11:0] OFF_STATUS  = 12'h008;
  localparam logic [11:0] OFF_FIFO    = 12'h00C;
  localparam logic [11:0] OFF_ID      = 12'h010;

  localparam logic [31:0] ID_VALUE = 32'h4D50_524A;

  localparam int CTRL_IRQ_EN_BIT   = 0;
  localparam int CTRL_FIFO_CLR_BIT = 1;

  localparam int STAT_EMPTY_BIT = 0;
  localparam int STAT_FULL_BIT  = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/mprj_mbox_fifo.sv
// Synchronous mailbox FIFO, 32-bit entries.
//   clk, rst_n : clock, asynchronous active-low reset (clears contents too)
//   push, din  : enqueue din; ignored while full
//   pop        : dequeue head; ignored while empty
//   clr        : empty the FIFO (priority over push/pop)
//   dout       : head entry, 0 while empty
//   empty, full, count : occupancy, count is $clog2(DEPTH)+1 bits
module mprj_mbox_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clr,
  input  logic [31:0]                din,
  output logic [31:0]                dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = empty ? 32'h0 : mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/mprj_wb_responder.sv
// Wishbone responder for the user-project side of the mprj bus.
// Decodes a 4 KB window at BASE_ADDR and serves SCRATCH, CTRL, STATUS,
// a mailbox FIFO and an ID word, with ACK_DELAY wait states.
//   core_clk, core_rstn : clock, asynchronous active-low reset
//   wbs_*_i             : Wishbone request (cyc, stb, we, sel, adr, dat)
//   wbs_ack_o           : one-cycle acknowledge (from state flop)
//   wbs_dat_o           : read data, loaded when the access commits
//   irq_o               : irq_en & (fifo not empty | overflow)
// Handshake: a request is cyc & stb & in-window, sampled in IDLE. The
// initiator must hold cyc/stb until ack; dropping either during the wait
// abandons the access with no side effect. Ack is high for one cycle and
// the responder always passes through IDLE before sampling again.
module mprj_wb_responder
  import mprj_wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          ACK_DELAY  = 1
) (
  input  logic        core_clk,
  input  logic        core_rstn,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_state_e   state;
  wb_state_e   next_state;
  logic [2:0]  wait_cnt;

  logic        lat_we;
  logic [3:0]  lat_sel;
  logic [11:0] lat_off;
  logic [31:0] lat_dat;

  logic        acc_we;
  logic [3:0]  acc_sel;
  logic [11:0] acc_off;
  logic [31:0] acc_dat;

  logic        hit;
  logic        req;
  logic        commit;

  logic [31:0] scratch;
  logic        irq_en;
  logic        overflow;

  logic        wr_scratch, wr_ctrl, wr_status;
  logic        fifo_push, fifo_pop, fifo_clr;
  logic [31:0] fifo_dout;
  logic        fifo_empty, fifo_full;
  logic [CW-1:0] fifo_count;
  logic [31:0] rdata;

  assign hit = (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign req = wbs_cyc_i & wbs_stb_i & hit;

  // With ACK_DELAY=0 the access commits on the same edge that samples it,
  // so the live bus fields are used in IDLE and the latched copy otherwise.
  assign acc_we  = (state == IDLE) ? wbs_we_i  : lat_we;
  assign acc_sel = (state == IDLE) ? wbs_sel_i : lat_sel;
  assign acc_off = (state == IDLE) ? {wbs_adr_i[11:2], 2'b00} : lat_off;
  assign acc_dat = (state == IDLE) ? wbs_dat_i : lat_dat;

  assign commit = (next_state == ACK) && (state != ACK);

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (req) next_state = (ACK_DELAY > 0) ? WAIT : ACK;
      WAIT: begin
        if (!(wbs_cyc_i && wbs_stb_i)) next_state = IDLE;
        else if (wait_cnt == 3'd0)     next_state = ACK;
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      state    <= IDLE;
      wait_cnt <= '0;
      lat_we   <= 1'b0;
      lat_sel  <= '0;
      lat_off  <= '0;
      lat_dat  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        wait_cnt <= (ACK_DELAY > 0) ? 3'(ACK_DELAY - 1) : 3'd0;
        lat_we   <= wbs_we_i;
        lat_sel  <= wbs_sel_i;
        lat_off  <= {wbs_adr_i[11:2], 2'b00};
        lat_dat  <= wbs_dat_i;
      end else if (state == WAIT && wait_cnt != 3'd0) begin
        wait_cnt <= wait_cnt - 3'd1;
      end
    end
  end

  assign wbs_ack_o = (state == ACK);

  // Side-effect strobes, all qualified by the committing edge.
  assign wr_scratch = commit & acc_we & (acc_off == OFF_SCRATCH);
  assign wr_ctrl    = commit & acc_we & (acc_off == OFF_CTRL);
  assign wr_status  = commit & acc_we & (acc_off == OFF_STATUS);
  assign fifo_push  = commit & acc_we & (acc_off == OFF_FIFO);
  assign fifo_pop   = commit & ~acc_we & (acc_off == OFF_FIFO);
  assign fifo_clr   = wr_ctrl & acc_dat[CTRL_FIFO_CLR_BIT];

  mprj_mbox_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (core_clk),
    .rst_n (core_rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clr   (fifo_clr),
    .din   (acc_dat),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn) begin
      scratch  <= '0;
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_scratch) begin
        for (int b = 0; b < 4; b++)
          if (acc_sel[b]) scratch[8*b +: 8] <= acc_dat[8*b +: 8];
      end
      if (wr_ctrl) irq_en <= acc_dat[CTRL_IRQ_EN_BIT];
      if (fifo_clr)                                  overflow <= 1'b0;
      else if (fifo_push && fifo_full)               overflow <= 1'b1;
      else if (wr_status && acc_dat[STAT_OVF_BIT])   overflow <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (acc_off)
      OFF_SCRATCH: rdata = scratch;
      OFF_CTRL:    rdata[CTRL_IRQ_EN_BIT] = irq_en;
      OFF_STATUS: begin
        rdata[STAT_EMPTY_BIT]             = fifo_empty;
        rdata[STAT_FULL_BIT]              = fifo_full;
        rdata[STAT_OVF_BIT]               = overflow;
        rdata[STAT_COUNT_LSB +: CW]       = fifo_count;
      end
      OFF_FIFO:    rdata = fifo_dout;
      OFF_ID:      rdata = ID_VALUE;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge core_clk or negedge core_rstn) begin
    if (!core_rstn)  wbs_dat_o <= '0;
    else if (commit) wbs_dat_o <= acc_we ? 32'h0 : rdata;
  end

  assign irq_o = irq_en & (~fifo_empty | overflow);

endmodule
